// File: rtl/runner_pkg.sv
// Game-logic render types shared with the scanner: sprite source rectangle and
// signed destination position, all in high-DPI (2x) pixel units.
package runner_pkg;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
  } pos_t;

endpackage

// File: rtl/slot_scanner_pkg.sv
// Shared types for the per-scanline sprite-slot scanner: draw descriptor,
// FSM state encoding and default screen geometry.
package slot_scanner_pkg;

  localparam int RENDER_SLOTS_DEFAULT = 32;
  localparam int SCREEN_W_DEFAULT     = 1200;
  localparam int SCREEN_H_DEFAULT     = 300;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  typedef struct packed {
    logic        [4:0]  slot;
    logic        [11:0] src_x;
    logic        [11:0] src_y;
    logic        [11:0] w;
    logic signed [11:0] dst_x;
  } desc_t;

endpackage

// File: rtl/slot_scanner_if.sv
// Descriptor stream from the slot scanner to the line blitter (valid/ready).
interface slot_scanner_if;
  import slot_scanner_pkg::*;

  logic  desc_valid;
  logic  desc_ready;
  desc_t desc;

  modport master (output desc_valid, output desc, input desc_ready);
  modport slave  (input desc_valid, input desc, output desc_ready);

endinterface

// File: rtl/slot_scanner_slot_test.sv
// Combinational per-slot visibility test and descriptor build for one line.
// SLOT_SCANNER_CLIP_EN clips the emitted descriptor horizontally to [0, SCREEN_W).
module slot_test
  import runner_pkg::*;
  import slot_scanner_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int IDX_W    = 5
) (
  input  sprite_t           spr,
  input  pos_t              pos,
  input  logic [10:0]       line_y,
  input  logic [IDX_W-1:0]  slot,
  output logic              visible,
  output desc_t             desc
);

  localparam logic signed [12:0] W13 = 13'(SCREEN_W);

  logic signed [12:0] px, py, ly, y_end, x_end;

  // Visibility is evaluated in 13-bit signed so negative positions compare correctly.
  assign px    = {pos.x[11], pos.x};
  assign py    = {pos.y[11], pos.y};
  assign ly    = {2'b00, line_y};
  assign y_end = py + $signed({1'b0, spr.h});
  assign x_end = px + $signed({1'b0, spr.w});

  assign visible = (spr.w != '0) && (spr.h != '0) &&
                   (py <= ly) && (ly < y_end) &&
                   (px < W13) && (x_end > 13'sd0);

`ifdef SLOT_SCANNER_CLIP_EN
  localparam logic signed [13:0] W14 = 14'(SCREEN_W);
  logic signed [13:0] cx, cw;
  logic        [11:0] csx;
`endif

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    desc       = '0;
    desc.slot  = 5'(slot);
    desc.src_y = spr.y + 12'(ly - py);
`ifdef SLOT_SCANNER_CLIP_EN
    cx  = {px[12], px};
    cw  = {2'b00, spr.w};
    csx = spr.x;
    if (cx < 14'sd0) begin
      csx = spr.x + 12'(-cx);
      cw  = cw + cx;
      cx  = '0;
    end
    if (cx + cw > W14) cw = W14 - cx;
    desc.src_x = csx;
    desc.w     = 12'(cw);
    desc.dst_x = 12'(cx);
`else
    desc.src_x = spr.x;
    desc.w     = spr.w;
    desc.dst_x = pos.x;
`endif
  end

endmodule

// File: rtl/slot_scanner.sv
// Per-scanline sprite-slot scanner: snapshots all slots on frame_start, then on
// each line_start emits one descriptor per intersecting slot in ascending order.
// Optional horizontal clipping: define SLOT_SCANNER_CLIP_EN.
module slot_scanner
  import runner_pkg::*;
  import slot_scanner_pkg::*;
#(
  parameter int RENDER_SLOTS = RENDER_SLOTS_DEFAULT,
  parameter int SCREEN_W     = SCREEN_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  sprite_t         sprite [RENDER_SLOTS],
  input  pos_t            pos    [RENDER_SLOTS],
  input  logic            frame_start,
  input  logic            line_start,
  input  logic [10:0]     line_y,
  slot_scanner_if.master  dbus,
  output logic            line_done,
  output logic            overrun
);

  localparam int IDX_W = (RENDER_SLOTS > 1) ? $clog2(RENDER_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(RENDER_SLOTS - 1);

  state_e           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [10:0]      line_q;
  logic             load_line, load_desc, visible;
  desc_t            desc_q, desc_c;
  sprite_t          spr_sh [RENDER_SLOTS];
  pos_t             pos_sh [RENDER_SLOTS];

  // NOTE: the shadow array is reset because a never-loaded frame must scan as all-invisible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spr_sh <= '{default: '0};
      pos_sh <= '{default: '0};
    end else if (frame_start) begin
      spr_sh <= sprite;
      pos_sh <= pos;
    end
  end

  slot_test #(.SCREEN_W(SCREEN_W), .IDX_W(IDX_W)) u_slot_test (
    .spr     (spr_sh[idx]),
    .pos     (pos_sh[idx]),
    .line_y  (line_q),
    .slot    (idx),
    .visible (visible),
    .desc    (desc_c)
  );

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    load_line = 1'b0;
    load_desc = 1'b0;
    if (frame_start) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: if (line_start) begin
          state_d   = SCAN;
          idx_d     = '0;
          load_line = 1'b1;
        end
        SCAN: begin
          if (visible) begin
            load_desc = 1'b1;
            state_d   = EMIT;
          end else if (idx == LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
        EMIT: if (dbus.desc_ready) begin
          if (idx == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = SCAN;
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      line_q  <= '0;
      desc_q  <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (load_line) line_q <= line_y;
      if (load_desc) desc_q <= desc_c;
      if (frame_start)                      overrun <= 1'b0;
      else if (line_start && state != IDLE) overrun <= 1'b1;
    end
  end

  assign dbus.desc_valid = (state == EMIT);
  assign dbus.desc       = desc_q;
  assign line_done       = (state == DONE);

endmodule

// File: tb/tb_slot_scanner.sv
// Self-checking bench for slot_scanner: directed scenarios plus randomized frames
// checked against a rule-level model of which slots intersect each line.
module tb_slot_scanner;
  import runner_pkg::*;
  import slot_scanner_pkg::*;

  localparam int N  = 32;
  localparam int SW = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  sprite_t     spr_in [N];
  pos_t        pos_in [N];
  logic        frame_start = 1'b0;
  logic        line_start  = 1'b0;
  logic [10:0] line_y      = '0;
  logic        line_done, overrun;

  slot_scanner_if dbus();

  slot_scanner #(.RENDER_SLOTS(N), .SCREEN_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sprite      (spr_in),
    .pos         (pos_in),
    .frame_start (frame_start),
    .line_start  (line_start),
    .line_y      (line_y),
    .dbus        (dbus),
    .line_done   (line_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_bad = 0;
  sprite_t m_spr [N];
  pos_t    m_pos [N];
  desc_t   exp_q[$];
  desc_t   got_q[$];

  // Reference: every slot in the snapshot that overlaps the line, in index order.
  function automatic void build_expected(input int ly);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      int px, py, w, h, sx;
      desc_t d;
      px = int'(m_pos[i].x);
      py = int'(m_pos[i].y);
      w  = int'(m_spr[i].w);
      h  = int'(m_spr[i].h);
      sx = int'(m_spr[i].x);
      if (w == 0 || h == 0) continue;
      if (!(py <= ly && ly < py + h)) continue;
      if (!(px < SW && px + w > 0)) continue;
      d.src_y = 12'(int'(m_spr[i].y) + ly - py);
`ifdef SLOT_SCANNER_CLIP_EN
      if (px < 0) begin
        sx = sx - px;
        w  = w + px;
        px = 0;
      end
      if (px + w > SW) w = SW - px;
`endif
      d.slot  = 5'(i);
      d.src_x = 12'(sx);
      d.w     = 12'(w);
      d.dst_x = 12'(px);
      exp_q.push_back(d);
    end
  endfunction

  task automatic clear_live();
    for (int i = 0; i < N; i++) begin
      spr_in[i] = '0;
      pos_in[i] = '0;
    end
  endtask

  task automatic rand_live();
    for (int i = 0; i < N; i++) begin
      spr_in[i].x = 12'($urandom);
      spr_in[i].y = 12'($urandom);
      spr_in[i].w = ($urandom_range(9) == 0) ? 12'd0 : 12'($urandom_range(300, 1));
      spr_in[i].h = ($urandom_range(9) == 0) ? 12'd0 : 12'($urandom_range(200, 1));
      pos_in[i].x = 12'(int'($urandom_range(1800)) - 400);
      pos_in[i].y = 12'(int'($urandom_range(600)) - 200);
    end
  endtask

  task automatic do_frame();
    @(negedge clk);
    frame_start = 1'b1;
    m_spr = spr_in;
    m_pos = pos_in;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Scans one line, scoring each handshake against the model, stall stability,
  // descriptor count and line_done timing. poke > 0 re-pulses line_start that cycle.
  task automatic run_line(input int ly, input int ready_pct, input int hold,
                          input int poke, input string tag);
    desc_t prev;
    bit    pending = 0;
    bit    done = 0;
    int    cyc = 0, n = 0, valid_cycles = 0, stalls = 0;
    build_expected(ly);
    got_q.delete();
    @(negedge clk);
    line_y = 11'(ly);
    line_start = 1'b1;
    dbus.desc_ready = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      line_start = (cyc == poke);
      if (pending) begin
        n_cmp++;
        if (dbus.desc_valid !== 1'b1 || dbus.desc !== prev) begin
          n_bad++;
          $display("FAIL %s stall_hold cyc %0d: valid %b desc %h, required valid 1 desc %h",
                   tag, cyc, dbus.desc_valid, dbus.desc, prev);
        end
      end
      if (dbus.desc_valid === 1'b1) begin
        valid_cycles++;
        if (stalls < hold) begin
          dbus.desc_ready = 1'b0;
          stalls++;
        end else begin
          dbus.desc_ready = ($urandom_range(99) < ready_pct);
        end
        if (dbus.desc_ready) begin
          got_q.push_back(dbus.desc);
          n_cmp++;
          if (n >= exp_q.size()) begin
            n_bad++;
            $display("FAIL %s extra_desc: got %h, required none", tag, dbus.desc);
          end else if (dbus.desc !== exp_q[n]) begin
            n_bad++;
            $display("FAIL %s desc[%0d] line %0d: got %h, required %h",
                     tag, n, ly, dbus.desc, exp_q[n]);
          end
          n++;
          pending = 0;
        end else begin
          pending = 1;
          prev = dbus.desc;
        end
      end else begin
        dbus.desc_ready = 1'($urandom_range(1));
        pending = 0;
      end
      if (line_done === 1'b1) done = 1;
    end
    dbus.desc_ready = 1'b0;
    line_start = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s line_done_timeout: got none in %0d cycles, required a pulse", tag, cyc);
    end
    n_cmp++;
    if (n != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s desc_count: got %0d, required %0d", tag, n, exp_q.size());
    end
    n_cmp++;
    if (done && cyc != 1 + N + valid_cycles) begin
      n_bad++;
      $display("FAIL %s line_done_cycle: got %0d, required %0d", tag, cyc, 1 + N + valid_cycles);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (dbus.desc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", dbus.desc_valid); end
    if (dbus.desc !== '0)         begin n_bad++; $display("FAIL reset_desc: got %h, required 0", dbus.desc); end
    if (line_done !== 1'b0)       begin n_bad++; $display("FAIL reset_line_done: got %b, required 0", line_done); end
    if (overrun !== 1'b0)         begin n_bad++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    rst = 1'b1;
    run_line(10, 100, 0, 0, "empty_after_reset");
  endtask

  task automatic test_slot29();
    desc_t d29;
    d29 = '{slot: 5'd29, src_x: 12'd1678, src_y: 12'd52, w: 12'd88, dst_x: 12'sd100};
    clear_live();
    spr_in[29] = '{x: 12'd1678, y: 12'd2, w: 12'd88, h: 12'd94};
    pos_in[29] = '{x: 12'sd100, y: 12'sd200};
    do_frame();
    run_line(250, 100, 0, 0, "slot29");
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== d29) begin
      n_bad++;
      $display("FAIL slot29_const: got %0d descs first %h, required 1 desc %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : desc_t'('0), d29);
    end
  endtask

  task automatic test_order_stall();
    clear_live();
    spr_in[0] = '{x: 12'd10,  y: 12'd20, w: 12'd40, h: 12'd30};
    pos_in[0] = '{x: 12'sd50, y: 12'sd10};
    spr_in[3] = '{x: 12'd1,   y: 12'd1,  w: 12'd10, h: 12'd10};
    pos_in[3] = '{x: 12'sd0,  y: 12'sd100};
    spr_in[7] = '{x: 12'd100, y: 12'd0,  w: 12'd60, h: 12'd5};
    pos_in[7] = '{x: 12'sd300, y: 12'sd18};
    do_frame();
    run_line(20, 100, 5, 0, "order_stall");
    n_cmp++;
    if (got_q.size() != 2 || got_q[0].slot != 5'd0 || got_q[1].slot != 5'd7) begin
      n_bad++;
      $display("FAIL order: got %0d descs, required slots 0 then 7", got_q.size());
    end
  endtask

  task automatic test_clip();
    desc_t e2, e9;
`ifdef SLOT_SCANNER_CLIP_EN
    e2 = '{slot: 5'd2, src_x: 12'd120, src_y: 12'd5, w: 12'd30, dst_x: 12'sd0};
    e9 = '{slot: 5'd9, src_x: 12'd7,   src_y: 12'd5, w: 12'd20, dst_x: 12'sd1180};
`else
    e2 = '{slot: 5'd2, src_x: 12'd100, src_y: 12'd5, w: 12'd50, dst_x: -12'sd20};
    e9 = '{slot: 5'd9, src_x: 12'd7,   src_y: 12'd5, w: 12'd50, dst_x: 12'sd1180};
`endif
    clear_live();
    spr_in[2] = '{x: 12'd100, y: 12'd0, w: 12'd50, h: 12'd10};
    pos_in[2] = '{x: -12'sd20, y: 12'sd0};
    spr_in[5] = '{x: 12'd0,   y: 12'd0, w: 12'd50, h: 12'd10};
    pos_in[5] = '{x: -12'sd50, y: 12'sd0};
    spr_in[9] = '{x: 12'd7,   y: 12'd0, w: 12'd50, h: 12'd10};
    pos_in[9] = '{x: 12'sd1180, y: 12'sd0};
    do_frame();
    run_line(5, 100, 0, 0, "clip");
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== e2 || got_q[1] !== e9) begin
      n_bad++;
      $display("FAIL clip_const: got %0d descs, required %h then %h", got_q.size(), e2, e9);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      rand_live();
      do_frame();
      rand_live();
      for (int l = 0; l < 4; l++)
        run_line(int'($urandom_range(299)), 40 + 15 * l, 0, 0, "random");
    end
  endtask

  task automatic test_overrun();
    int seen = 0;
    rand_live();
    do_frame();
    run_line(int'($urandom_range(299)), 70, 0, 4, "overrun_scan");
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b, required 1", overrun); end

    clear_live();
    spr_in[0] = '{x: 12'd10, y: 12'd20, w: 12'd40, h: 12'd30};
    pos_in[0] = '{x: 12'sd50, y: 12'sd10};
    do_frame();
    rand_live();
    @(negedge clk);
    line_y = 11'd20;
    line_start = 1'b1;
    dbus.desc_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    line_start = 1'b0;
    n_cmp += 2;
    if (dbus.desc_valid !== 1'b1) begin n_bad++; $display("FAIL emit_before_abort: got %b, required 1", dbus.desc_valid); end
    if (overrun !== 1'b1)         begin n_bad++; $display("FAIL overrun_before_abort: got %b, required 1", overrun); end
    frame_start = 1'b1;
    m_spr = spr_in;
    m_pos = pos_in;
    @(negedge clk);
    frame_start = 1'b0;
    n_cmp += 2;
    if (dbus.desc_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b, required 0", dbus.desc_valid); end
    if (overrun !== 1'b0)         begin n_bad++; $display("FAIL abort_overrun: got %b, required 0", overrun); end
    repeat (40) begin
      @(negedge clk);
      if (line_done !== 1'b0 || dbus.desc_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles, required 0", seen); end
    run_line(int'($urandom_range(299)), 80, 0, 0, "after_abort");

    rand_live();
    @(negedge clk);
    frame_start = 1'b1;
    line_start = 1'b1;
    line_y = 11'($urandom_range(299));
    m_spr = spr_in;
    m_pos = pos_in;
    @(negedge clk);
    frame_start = 1'b0;
    line_start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (line_done !== 1'b0 || dbus.desc_valid !== 1'b0 || overrun !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL coincide_quiet: got %0d active cycles, required 0", seen); end
  endtask

  task automatic test_reset_mid_emit();
    clear_live();
    spr_in[0] = '{x: 12'd10, y: 12'd20, w: 12'd40, h: 12'd30};
    pos_in[0] = '{x: 12'sd50, y: 12'sd10};
    do_frame();
    @(negedge clk);
    line_y = 11'd20;
    line_start = 1'b1;
    dbus.desc_ready = 1'b0;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbus.desc_valid !== 1'b1) begin n_bad++; $display("FAIL emit_before_reset: got %b, required 1", dbus.desc_valid); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (dbus.desc_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got %b, required 0", dbus.desc_valid); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_spr[i] = '0;
      m_pos[i] = '0;
    end
    run_line(20, 100, 0, 0, "post_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    dbus.desc_ready = 1'b0;
    clear_live();
    for (int i = 0; i < N; i++) begin
      m_spr[i] = '0;
      m_pos[i] = '0;
    end
    test_reset();
    test_slot29();
    test_order_stall();
    test_clip();
    test_random();
    test_overrun();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
